regfile_read_arbiter: RTL

- Owns a 16 x 32-bit register array with one write port and one shared read port.
- The read port is the 16:1 word-select path (4-bit select, 32-bit word).
- Shares that single read port between NUM_REQ requesters (fetch, decode, debug, ...) using a round-robin arbiter with a valid/ready handshake.
- Returns registered read data one cycle after grant, tagged with the requester ID.

---
 rtl/regfile_read_arbiter_pkg.sv | 14 +
 rtl/regfile_read_arbiter_rr_arbiter.sv | 52 +++++
 rtl/regfile_read_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants for the register-file read arbiter slice:
// array geometry and the IDs of the standard read requesters.
package regfile_read_arbiter_pkg;

    localparam int unsigned REG_DEPTH = 16;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 4;

    localparam int unsigned REQ_FETCH  = 0;
    localparam int unsigned REQ_DECODE = 1;
    localparam int unsigned REQ_EXEC   = 2;
    localparam int unsigned REQ_DEBUG  = 3;

endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, scanning upward from the
// requester after the last one granted. The pointer moves only on a grant.
module regfile_read_arbiter_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_vld_o
);
    import regfile_read_arbiter_pkg::*;

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] last_d;

    // Reset leaves the pointer on the top requester so requester 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= ID_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        int unsigned cand;
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        last_d      = last_q;
        cand        = 0;
        if (!rst_i) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = (32'(last_q) + 32'd1 + k) % NUM_REQ;
                if (!grant_vld_o && req_i[IDX_W'(cand)]) begin
                    grant_o[IDX_W'(cand)] = 1'b1;
                    grant_idx_o           = ID_W'(cand);
                    grant_vld_o           = 1'b1;
                end
            end
        end
        if (grant_vld_o) begin
            last_d = grant_idx_o;
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// 16 x 32 register file with one write port and one read port shared by
// NUM_REQ requesters through a round-robin arbiter; read data is registered.
module regfile_read_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    input  logic [ADDR_W-1:0]         wr_addr_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      rsp_valid_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_data_o
);
    import regfile_read_arbiter_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_vld;

    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

    regfile_read_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_valid_i),
        .grant_o     (req_ready_o),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Write-first: a same-cycle write to the granted address is forwarded.
    always_comb begin
        rd_addr = addr_arr[grant_idx];
        rd_data = regs_q[rd_addr];
        if (wr_en_i && (wr_addr_i == rd_addr)) begin
            rd_data = wr_data_i;
        end
    end

    always_comb begin
        rsp_valid_d = grant_vld;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (grant_vld) begin
            rsp_id_d   = grant_idx;
            rsp_data_d = rd_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;

endmodule
